// File: rtl/dtcm_arbiter_if.sv
// Bus bundle between the CPU memory stage, the external loader/debug port and the DTCM.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface dtcm_arbiter_if;
    logic        cpu_en;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    logic        ext_req;
    logic        ext_we;
    logic [3:0]  ext_be;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic        ext_err;
    logic [31:0] ext_rdata;

    logic        dtcm_en;
    logic        dtcm_we;
    logic [3:0]  dtcm_be;
    logic [31:0] dtcm_addr;
    logic [31:0] dtcm_wdata;
    logic [31:0] dtcm_rdata;

    modport slave (
        input  cpu_en, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_we, ext_be, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_err, ext_rdata,
        output dtcm_en, dtcm_we, dtcm_be, dtcm_addr, dtcm_wdata,
        input  dtcm_rdata
    );

    modport master (
        output cpu_en, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_req, ext_we, ext_be, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_err, ext_rdata,
        input  dtcm_en, dtcm_we, dtcm_be, dtcm_addr, dtcm_wdata,
        output dtcm_rdata
    );
endinterface

// File: rtl/dtcm_arbiter.sv
// Single-port DTCM arbiter: CPU priority with a bounded-wait escape for the external port,
// plus one-cycle read-response ownership tracking and out-of-range external error responses.
module dtcm_arbiter #(
    parameter int unsigned     MAX_WAIT   = 4,
    parameter longint unsigned DTCM_BYTES = 65536
) (
    input  logic          clk,
    input  logic          reset_n,
    dtcm_arbiter_if.slave bus
);
    localparam int unsigned      WW        = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]    WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [32:0]      ADDR_LIM  = 33'(DTCM_BYTES);

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_CPU,
        RSP_EXT,
        RSP_EXT_ERR
    } rsp_t;

    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    rsp_t          rsp_own;
    rsp_t          rsp_nxt;
    logic          ext_win;
    logic          cpu_win;
    logic          ext_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            rsp_own  <= RSP_NONE;
        end else begin
            wait_cnt <= wait_nxt;
            rsp_own  <= rsp_nxt;
        end
    end

    always_comb begin
        ext_in_range = ({1'b0, bus.ext_addr} < ADDR_LIM);
        ext_win      = bus.ext_req && (!bus.cpu_en || (wait_cnt == WAIT_MAX));
        cpu_win      = bus.cpu_en && !ext_win;

        // Port payload follows the external side only when it wins; otherwise the CPU drives it.
        bus.dtcm_be    = ext_win ? bus.ext_be    : bus.cpu_be;
        bus.dtcm_addr  = ext_win ? bus.ext_addr  : bus.cpu_addr;
        bus.dtcm_wdata = ext_win ? bus.ext_wdata : bus.cpu_wdata;
        bus.dtcm_en    = cpu_win || (ext_win && ext_in_range);
        bus.dtcm_we    = (ext_win ? bus.ext_we : bus.cpu_we) && bus.dtcm_en;

        bus.ext_gnt    = ext_win;
        bus.cpu_stall  = bus.cpu_en && ext_win;

        rsp_nxt = RSP_NONE;
        if (ext_win) begin
            if (!ext_in_range) begin
                rsp_nxt = RSP_EXT_ERR;
            end else if (!bus.ext_we) begin
                rsp_nxt = RSP_EXT;
            end
        end else if (cpu_win && !bus.cpu_we) begin
            rsp_nxt = RSP_CPU;
        end

        wait_nxt = wait_cnt;
        if (!bus.ext_req || ext_win) begin
            wait_nxt = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_nxt = wait_cnt + 1'b1;
        end

        bus.cpu_rvalid = (rsp_own == RSP_CPU);
        bus.ext_rvalid = (rsp_own == RSP_EXT) || (rsp_own == RSP_EXT_ERR);
        bus.ext_err    = (rsp_own == RSP_EXT_ERR);
        bus.cpu_rdata  = bus.dtcm_rdata;
        bus.ext_rdata  = (rsp_own == RSP_EXT_ERR) ? '0 : bus.dtcm_rdata;
    end
endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed bench for dtcm_arbiter with a small behavioural DTCM; expected values are hand-derived.
module tb_dtcm_arbiter;
    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    dtcm_arbiter_if bus();

    dtcm_arbiter #(
        .MAX_WAIT   (4),
        .DTCM_BYTES (65536)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 256-word DTCM model, preloaded while reset is held.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4]          <= 32'hCAFE_F00D;
            mem[8]          <= 32'h1234_5678;
            mem[9]          <= 32'h1111_1111;
            bus.dtcm_rdata  <= 32'h0;
        end else if (bus.dtcm_en) begin
            if (bus.dtcm_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.dtcm_be[b])
                        mem[bus.dtcm_addr[9:2]][8*b +: 8] <= bus.dtcm_wdata[8*b +: 8];
            end else begin
                bus.dtcm_rdata <= mem[bus.dtcm_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step_end();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wexp [0:5];
        n_assert = 0;
        n_fail   = 0;
        reset_n       = 1'b0;
        bus.cpu_en    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_be    = 4'h0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.ext_req   = 1'b0;
        bus.ext_we    = 1'b0;
        bus.ext_be    = 4'h0;
        bus.ext_addr  = 32'h0;
        bus.ext_wdata = 32'h0;
        wexp[0] = 32'd0; wexp[1] = 32'd1; wexp[2] = 32'd2;
        wexp[3] = 32'd3; wexp[4] = 32'd4; wexp[5] = 32'd0;

        // Reset / idle state
        step_end();
        step_end();
        @(negedge clk);
        chk("rst_cpu_stall",  32'(bus.cpu_stall),  32'd0);
        chk("rst_ext_gnt",    32'(bus.ext_gnt),    32'd0);
        chk("rst_dtcm_en",    32'(bus.dtcm_en),    32'd0);
        chk("rst_dtcm_we",    32'(bus.dtcm_we),    32'd0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
        chk("rst_ext_err",    32'(bus.ext_err),    32'd0);
        chk("rst_wait_cnt",   32'(dut.wait_cnt),   32'd0);
        step_end();
        reset_n = 1'b1;

        // Idle CPU, external read of 0x10
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h10; bus.ext_be = 4'hF;
        @(negedge clk);
        chk("t1_ext_gnt",   32'(bus.ext_gnt),   32'd1);
        chk("t1_dtcm_en",   32'(bus.dtcm_en),   32'd1);
        chk("t1_dtcm_we",   32'(bus.dtcm_we),   32'd0);
        chk("t1_dtcm_addr", bus.dtcm_addr,      32'h10);
        chk("t1_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        step_end();
        bus.ext_req = 1'b0;
        @(negedge clk);
        chk("t1_ext_rvalid", 32'(bus.ext_rvalid), 32'd1);
        chk("t1_ext_err",    32'(bus.ext_err),    32'd0);
        chk("t1_ext_rdata",  bus.ext_rdata,       32'hCAFE_F00D);
        chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        step_end();

        // Continuous CPU reads of 0x20 against an external read of 0x10
        bus.cpu_en = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) bus.ext_req = 1'b0;
            @(negedge clk);
            chk($sformatf("t2_wait_cnt_%0d", k),  32'(dut.wait_cnt),   wexp[k]);
            chk($sformatf("t2_ext_gnt_%0d", k),   32'(bus.ext_gnt),    (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t2_cpu_stall_%0d", k), 32'(bus.cpu_stall),  (k == 4) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk("t2_cpu_rvalid_1", 32'(bus.cpu_rvalid), 32'd1);
                chk("t2_cpu_rdata_1",  bus.cpu_rdata,       32'h1234_5678);
            end
            if (k == 4) chk("t2_dtcm_addr_4", bus.dtcm_addr, 32'h10);
            if (k == 5) begin
                chk("t2_ext_rvalid_5", 32'(bus.ext_rvalid), 32'd1);
                chk("t2_ext_rdata_5",  bus.ext_rdata,       32'hCAFE_F00D);
                chk("t2_cpu_rvalid_5", 32'(bus.cpu_rvalid), 32'd0);
            end
            step_end();
        end

        // CPU read 0x20 then external partial write 0x24
        bus.cpu_en = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
        @(negedge clk);
        chk("t3_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("t3_dtcm_en",   32'(bus.dtcm_en),   32'd1);
        step_end();
        bus.cpu_en = 1'b0;
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h24;
        bus.ext_be = 4'b0011; bus.ext_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("t3_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t3_cpu_rdata",  bus.cpu_rdata,       32'h1234_5678);
        chk("t3_ext_gnt",    32'(bus.ext_gnt),    32'd1);
        chk("t3_dtcm_we",    32'(bus.dtcm_we),    32'd1);
        chk("t3_dtcm_be",    32'(bus.dtcm_be),    32'h3);
        chk("t3_dtcm_wdata", bus.dtcm_wdata,      32'hA5A5_A5A5);
        step_end();
        bus.ext_req = 1'b0; bus.ext_we = 1'b0;
        bus.cpu_en = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h24;
        @(negedge clk);
        chk("t3_ext_rvalid_wr", 32'(bus.ext_rvalid), 32'd0);
        chk("t3_cpu_rvalid_wr", 32'(bus.cpu_rvalid), 32'd0);
        step_end();
        bus.cpu_en = 1'b0;
        @(negedge clk);
        chk("t3_readback", bus.cpu_rdata, 32'h1111_A5A5);
        step_end();

        // Out-of-range external read and write
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h0001_0000;
        @(negedge clk);
        chk("t4_ext_gnt",  32'(bus.ext_gnt), 32'd1);
        chk("t4_dtcm_en",  32'(bus.dtcm_en), 32'd0);
        step_end();
        bus.ext_we = 1'b1; bus.ext_addr = 32'hFFFF_FFF0;
        @(negedge clk);
        chk("t4_ext_rvalid", 32'(bus.ext_rvalid), 32'd1);
        chk("t4_ext_err",    32'(bus.ext_err),    32'd1);
        chk("t4_ext_rdata",  bus.ext_rdata,       32'h0);
        chk("t4w_dtcm_en",   32'(bus.dtcm_en),    32'd0);
        chk("t4w_dtcm_we",   32'(bus.dtcm_we),    32'd0);
        step_end();
        bus.ext_req = 1'b0; bus.ext_we = 1'b0;
        @(negedge clk);
        chk("t4w_ext_rvalid", 32'(bus.ext_rvalid), 32'd1);
        chk("t4w_ext_err",    32'(bus.ext_err),    32'd1);
        step_end();
        @(negedge clk);
        chk("t4_idle_rvalid", 32'(bus.ext_rvalid), 32'd0);
        step_end();

        // Withdrawn external request under CPU traffic
        bus.cpu_en = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
        bus.ext_req = 1'b1; bus.ext_addr = 32'h10;
        @(negedge clk);
        chk("t5_wait_a", 32'(dut.wait_cnt), 32'd0);
        chk("t5_gnt_a",  32'(bus.ext_gnt),  32'd0);
        step_end();
        @(negedge clk);
        chk("t5_wait_b", 32'(dut.wait_cnt), 32'd1);
        chk("t5_gnt_b",  32'(bus.ext_gnt),  32'd0);
        step_end();
        bus.ext_req = 1'b0;
        @(negedge clk);
        chk("t5_wait_c", 32'(dut.wait_cnt), 32'd2);
        step_end();
        @(negedge clk);
        chk("t5_wait_d", 32'(dut.wait_cnt), 32'd0);
        step_end();
        bus.ext_req = 1'b1;
        @(negedge clk);
        chk("t5_wait_e", 32'(dut.wait_cnt), 32'd0);
        chk("t5_gnt_e",  32'(bus.ext_gnt),  32'd0);
        step_end();
        @(negedge clk);
        chk("t5_wait_f", 32'(dut.wait_cnt), 32'd1);
        step_end();
        bus.ext_req = 1'b0;
        bus.cpu_en = 1'b0;
        step_end();
        step_end();

        // Reset pulsed right after a granted CPU read
        bus.cpu_en = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
        bus.ext_req = 1'b1; bus.ext_addr = 32'h10;
        @(negedge clk);
        chk("t6_cpu_win", 32'(bus.cpu_stall), 32'd0);
        step_end();
        reset_n = 1'b0;
        bus.cpu_en = 1'b0; bus.ext_req = 1'b0;
        @(negedge clk);
        chk("t6_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("t6_wait_cnt",   32'(dut.wait_cnt),   32'd0);
        step_end();
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_post_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        step_end();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
